// File: rtl/orbit_trail_plotter.sv
`default_nettype none
// =============================================================================
// Module  : orbit_trail_plotter
// Brief   : Scales signed orbit samples to screen pixels and keeps a trail of
//           the newest TRAIL_LEN points, erasing the oldest before each draw.
// Revision: 1.0 - initial release
// =============================================================================
module orbit_trail_plotter #(
    parameter int         COORD_W     = 27,
    parameter int         SCALE_SHIFT = 9,
    parameter int         SCREEN_W    = 640,
    parameter int         SCREEN_H    = 480,
    parameter int         CX          = 320,
    parameter int         CY          = 240,
    parameter int         TRAIL_LEN   = 16,
    parameter logic [7:0] DRAW_COLOR  = 8'hFF,
    parameter logic [7:0] BG_COLOR    = 8'h00
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_valid,
    output logic                         sample_ready,
    input  logic [COORD_W-1:0]           sample_x,
    input  logic [COORD_W-1:0]           sample_y,
    input  logic                         clear,
    output logic                         pix_req,
    input  logic                         pix_ack,
    output logic [9:0]                   pix_x,
    output logic [8:0]                   pix_y,
    output logic [7:0]                   pix_color,
    output logic                         drop,
    output logic [$clog2(TRAIL_LEN):0]   trail_count
);

    localparam int PTR_W = $clog2(TRAIL_LEN);
    localparam int CNT_W = PTR_W + 1;

    localparam logic signed [COORD_W:0] CX_S = (COORD_W+1)'(CX);
    localparam logic signed [COORD_W:0] CY_S = (COORD_W+1)'(CY);
    localparam logic signed [COORD_W:0] SW_S = (COORD_W+1)'(SCREEN_W);
    localparam logic signed [COORD_W:0] SH_S = (COORD_W+1)'(SCREEN_H);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALC  = 3'd1,
        S_ERASE = 3'd2,
        S_DRAW  = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    state_t               state_q,     state_d;
    logic                 ready_q,     ready_d;
    logic [COORD_W-1:0]   samp_x_q,    samp_x_d;
    logic [COORD_W-1:0]   samp_y_q,    samp_y_d;
    logic [9:0]           pt_x_q,      pt_x_d;
    logic [8:0]           pt_y_q,      pt_y_d;
    logic [PTR_W-1:0]     rd_ptr_q,    rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q,    wr_ptr_d;
    logic [CNT_W-1:0]     count_q,     count_d;
    logic                 pix_req_q,   pix_req_d;
    logic [9:0]           pix_x_q,     pix_x_d;
    logic [8:0]           pix_y_q,     pix_y_d;
    logic [7:0]           pix_color_q, pix_color_d;
    logic                 drop_q,      drop_d;

    logic [9:0]           trail_x_q [TRAIL_LEN];
    logic [8:0]           trail_y_q [TRAIL_LEN];

    logic                 push;
    logic                 pop;
    logic signed [COORD_W:0] ext_x, ext_y, sx_w, sy_w;
    logic                 on_screen;
    logic                 is_repeat;
    logic [PTR_W-1:0]     last_ptr;
    logic                 hs_done;

    // Sign-extend by one bit so the centre offset can never overflow.
    always_comb begin
        ext_x     = $signed({samp_x_q[COORD_W-1], samp_x_q});
        ext_y     = $signed({samp_y_q[COORD_W-1], samp_y_q});
        sx_w      = CX_S + (ext_x >>> SCALE_SHIFT);
        sy_w      = CY_S - (ext_y >>> SCALE_SHIFT);
        on_screen = !sx_w[COORD_W] && !sy_w[COORD_W] && (sx_w < SW_S) && (sy_w < SH_S);
        last_ptr  = wr_ptr_q - PTR_W'(1);
        is_repeat = (count_q != '0) && (trail_x_q[last_ptr] == sx_w[9:0])
                    && (trail_y_q[last_ptr] == sy_w[8:0]);
        hs_done   = pix_req_q && pix_ack;
    end

    always_comb begin
        state_d     = state_q;
        samp_x_d    = samp_x_q;
        samp_y_d    = samp_y_q;
        pt_x_d      = pt_x_q;
        pt_y_d      = pt_y_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        pix_req_d   = pix_req_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_color_d = pix_color_q;
        drop_d      = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ready_q) begin
                    if (clear) begin
                        state_d = S_FLUSH;
                    end else if (sample_valid) begin
                        samp_x_d = sample_x;
                        samp_y_d = sample_y;
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                state_d = S_IDLE;
                if (!on_screen) begin
                    drop_d = 1'b1;
                end else if (!is_repeat) begin
                    pt_x_d    = sx_w[9:0];
                    pt_y_d    = sy_w[8:0];
                    pix_req_d = 1'b1;
                    if (count_q == CNT_W'(TRAIL_LEN)) begin
                        state_d     = S_ERASE;
                        pix_x_d     = trail_x_q[rd_ptr_q];
                        pix_y_d     = trail_y_q[rd_ptr_q];
                        pix_color_d = BG_COLOR;
                    end else begin
                        state_d     = S_DRAW;
                        pix_x_d     = sx_w[9:0];
                        pix_y_d     = sy_w[8:0];
                        pix_color_d = DRAW_COLOR;
                    end
                end
            end
            S_ERASE: begin
                if (hs_done) begin
                    pix_req_d = 1'b0;
                    pop       = 1'b1;
                    state_d   = S_DRAW;
                end else if (!pix_req_q) begin
                    pix_req_d   = 1'b1;
                    pix_x_d     = trail_x_q[rd_ptr_q];
                    pix_y_d     = trail_y_q[rd_ptr_q];
                    pix_color_d = BG_COLOR;
                end
            end
            S_DRAW: begin
                if (hs_done) begin
                    pix_req_d = 1'b0;
                    push      = 1'b1;
                    state_d   = S_IDLE;
                end else if (!pix_req_q) begin
                    pix_req_d   = 1'b1;
                    pix_x_d     = pt_x_q;
                    pix_y_d     = pt_y_q;
                    pix_color_d = DRAW_COLOR;
                end
            end
            S_FLUSH: begin
                if (hs_done) begin
                    pix_req_d = 1'b0;
                    pop       = 1'b1;
                end else if (!pix_req_q) begin
                    if (count_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        pix_req_d   = 1'b1;
                        pix_x_d     = trail_x_q[rd_ptr_q];
                        pix_y_d     = trail_y_q[rd_ptr_q];
                        pix_color_d = BG_COLOR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop && (count_q != '0)) begin
            count_d  = count_q - CNT_W'(1);
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && (count_q != CNT_W'(TRAIL_LEN))) begin
            count_d  = count_q + CNT_W'(1);
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        // Registered ready keeps it low throughout reset and for the first edge after.
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            samp_x_q    <= '0;
            samp_y_q    <= '0;
            pt_x_q      <= '0;
            pt_y_q      <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            pix_req_q   <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_color_q <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            samp_x_q    <= samp_x_d;
            samp_y_q    <= samp_y_d;
            pt_x_q      <= pt_x_d;
            pt_y_q      <= pt_y_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            pix_req_q   <= pix_req_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_color_q <= pix_color_d;
            drop_q      <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            trail_x_q[wr_ptr_q] <= pt_x_q;
            trail_y_q[wr_ptr_q] <= pt_y_q;
        end
    end

    assign sample_ready = ready_q;
    assign pix_req      = pix_req_q;
    assign pix_x        = pix_x_q;
    assign pix_y        = pix_y_q;
    assign pix_color    = pix_color_q;
    assign drop         = drop_q;
    assign trail_count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_orbit_trail_plotter.sv
`default_nettype none
// =============================================================================
// Module  : tb_orbit_trail_plotter
// Brief   : Directed bench with a queue-based trail model and a per-cycle
//           pixel-write checker for orbit_trail_plotter.
// Revision: 1.0 - initial release
// =============================================================================
module tb_orbit_trail_plotter;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic        sample_ready;
    logic [26:0] sample_x;
    logic [26:0] sample_y;
    logic        clear;
    logic        pix_req;
    logic        pix_ack;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [7:0]  pix_color;
    logic        drop;
    logic [4:0]  trail_count;

    always #5 clk = ~clk;

    orbit_trail_plotter dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_x     (sample_x),
        .sample_y     (sample_y),
        .clear        (clear),
        .pix_req      (pix_req),
        .pix_ack      (pix_ack),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_color    (pix_color),
        .drop         (drop),
        .trail_count  (trail_count)
    );

    typedef struct {
        int x;
        int y;
        int c;
    } wr_t;

    int  vectors    = 0;
    int  miscompares = 0;
    wr_t exp_q[$];
    wr_t log_q[$];
    int  trail_x[$];
    int  trail_y[$];
    int  drop_cnt   = 0;
    int  ack_delay  = 0;

    function automatic void check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Frame-buffer side: ack either held high, or raised after ack_delay cycles of request.
    initial begin
        int cnt;
        cnt     = 0;
        pix_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ack_delay == 0) begin
                pix_ack = 1'b1;
            end else if (pix_req) begin
                pix_ack = (cnt >= ack_delay);
                cnt++;
            end else begin
                cnt     = 0;
                pix_ack = 1'b0;
            end
        end
    end

    // Every cycle with a request, the presented pixel must be the model's next write.
    initial begin
        bit prev_req;
        bit prev_ack;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
                prev_ack = 1'b0;
            end else begin
                if (prev_req && !prev_ack) check("req_held", pix_req, 1);
                if (prev_req && prev_ack)  check("req_gap", pix_req, 0);
                if (pix_req) begin
                    check("ready_during_req", sample_ready, 0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 1, 0);
                    end else begin
                        check("pix_x", pix_x, exp_q[0].x);
                        check("pix_y", pix_y, exp_q[0].y);
                        check("pix_color", pix_color, exp_q[0].c);
                        if (pix_ack) begin
                            log_q.push_back(exp_q[0]);
                            exp_q.pop_front();
                        end
                    end
                end
                if (drop) drop_cnt++;
                prev_req = pix_req;
                prev_ack = pix_ack;
            end
        end
    end

    function automatic void model_sample(int x, int y, output bit wr, output bit dr);
        int sx, sy, n;
        sx = 320 + (x >>> 9);
        sy = 240 - (y >>> 9);
        n  = trail_x.size();
        wr = 1'b0;
        dr = 1'b0;
        if (sx < 0 || sx >= 640 || sy < 0 || sy >= 480) begin
            dr = 1'b1;
        end else if (n > 0 && trail_x[n-1] == sx && trail_y[n-1] == sy) begin
            wr = 1'b0;
        end else begin
            wr = 1'b1;
            if (n == 16) begin
                exp_q.push_back('{trail_x[0], trail_y[0], 0});
                void'(trail_x.pop_front());
                void'(trail_y.pop_front());
            end
            exp_q.push_back('{sx, sy, 255});
            trail_x.push_back(sx);
            trail_y.push_back(sy);
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < trail_x.size(); i++) exp_q.push_back('{trail_x[i], trail_y[i], 0});
        trail_x.delete();
        trail_y.delete();
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        trail_x.delete();
        trail_y.delete();
    endfunction

    task automatic wait_ready(string name);
        int n;
        n = 0;
        while (!sample_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!sample_ready) check(name, 0, 1);
    endtask

    task automatic send(int x, int y, bit with_clear, bit wait_done);
        bit wr, dr;
        int d0;
        d0 = drop_cnt;
        wait_ready("ready_timeout");
        if (with_clear) begin
            clear = 1'b1;
            model_clear();
        end
        sample_valid = 1'b1;
        sample_x     = 27'(x);
        sample_y     = 27'(y);
        model_sample(x, y, wr, dr);
        if (with_clear) begin
            @(negedge clk);
            clear = 1'b0;
            @(negedge clk);
            wait_ready("held_sample_timeout");
        end
        @(negedge clk);
        sample_valid = 1'b0;
        check("calc_cycle_req", pix_req, 0);
        @(negedge clk);
        check("latency_t2_req", pix_req, int'(wr));
        if (wait_done) begin
            wait_ready("done_timeout");
            check("pending_writes", exp_q.size(), 0);
            check("trail_count", trail_count, trail_x.size());
            check("drop_pulses", drop_cnt - d0, int'(dr));
        end
    endtask

    task automatic release_reset();
        rst = 1'b0;
        check("ready_low_after_rst", sample_ready, 0);
        @(negedge clk);
        check("ready_rises", sample_ready, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        release_reset();
    endtask

    task automatic check_log(int back, int x, int y, int c);
        int idx;
        idx = log_q.size() - 1 - back;
        if (idx < 0) begin
            check("log_entry_missing", idx, 0);
        end else begin
            check("lit_x", log_q[idx].x, x);
            check("lit_y", log_q[idx].y, y);
            check("lit_color", log_q[idx].c, c);
        end
    endtask

    initial begin
        int n0;
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_x     = '0;
        sample_y     = '0;
        clear        = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pix_req", pix_req, 0);
        check("rst_ready", sample_ready, 0);
        check("rst_count", trail_count, 0);
        check("rst_drop", drop, 0);
        check("rst_pix_x", pix_x, 0);
        release_reset();

        // First point lands on the orbit origin.
        send(0, 0, 0, 1);
        check_log(0, 320, 240, 255);
        check("lit_count_1", trail_count, 1);

        send(51200, 0, 0, 1);
        check_log(0, 420, 240, 255);
        send(0, 25600, 0, 1);
        check_log(0, 320, 190, 255);
        send(-51200, 0, 0, 1);
        check_log(0, 220, 240, 255);

        // Off-screen drops and repeats of the newest point.
        send(200000, 0, 0, 1);
        check("lit_count_4", trail_count, 4);
        n0 = log_q.size();
        send(-51200, 0, 0, 1);
        send(-51000, 100, 0, 1);
        check("lit_repeat_no_write", log_q.size(), n0);
        send(163840, 0, 0, 1);
        send(163328, 0, 0, 1);
        check_log(0, 639, 240, 255);
        send(0, 241 * 512, 0, 1);
        send(0, -239 * 512, 0, 1);
        check_log(0, 320, 479, 255);
        send(-321 * 512, 0, 0, 1);
        send(-320 * 512, 0, 0, 1);
        check_log(0, 0, 240, 255);

        // Seventeen distinct points from empty: the 17th evicts the first.
        do_reset();
        for (int i = 0; i < 17; i++) send((i * 10 - 80) * 512, (i * 5) * 512, 0, 1);
        check_log(1, 240, 240, 0);
        check_log(0, 400, 160, 255);
        check("lit_count_16", trail_count, 16);

        // Slow frame buffer, then reset while a request is outstanding.
        do_reset();
        ack_delay = 5;
        send(1024, 1024, 0, 1);
        check_log(0, 322, 238, 255);
        ack_delay = 1000;
        send(2048, 0, 0, 0);
        check("req_before_rst", pix_req, 1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_drops_req", pix_req, 0);
        check("rst_count_0", trail_count, 0);
        check("rst_ready_0", sample_ready, 0);
        ack_delay = 0;
        @(negedge clk);
        @(negedge clk);
        release_reset();

        // Clear and sample together: flush wins, held sample follows.
        send(0, 0, 0, 1);
        send(512, 0, 0, 1);
        send(1024, 0, 0, 1);
        send(5120, 0, 1, 1);
        check_log(3, 320, 240, 0);
        check_log(2, 321, 240, 0);
        check_log(1, 322, 240, 0);
        check_log(0, 330, 240, 255);
        check("lit_count_after_clear", trail_count, 1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
